// File: rtl/lcd_bus_monitor_if.sv
// Bundle of LCD bus pins and monitor results for lcd_bus_monitor.
// master: the LCD driver side (drives LCDE/RS/RW/DAT, observes results).
// slave:  the monitor side (samples the bus, drives the decoded state).
interface lcd_bus_monitor_if;
  logic         LCDE;
  logic         LCDRS;
  logic         LCDRW;
  logic [3:0]   LCDDAT;
  logic [255:0] strdata;
  logic [4:0]   cursor;
  logic         disp_on;
  logic         four_bit;
  logic         byte_valid;
  logic [7:0]   byte_out;
  logic         byte_rs;
  logic         proto_err;

  modport master (
    output LCDE, LCDRS, LCDRW, LCDDAT,
    input  strdata, cursor, disp_on, four_bit, byte_valid, byte_out, byte_rs, proto_err
  );

  modport slave (
    input  LCDE, LCDRS, LCDRW, LCDDAT,
    output strdata, cursor, disp_on, four_bit, byte_valid, byte_out, byte_rs, proto_err
  );
endinterface

// File: rtl/lcd_bus_monitor.sv
// Receive-side model of a 4-bit HD44780 bus: reassembles nibbles and keeps a 2x16 display buffer.
// Latency: decoded state updates SYNC_STAGES+1 CCLK edges after LCDE first samples low.
// Backpressure: none; the monitor is passive and accepts every strobe.
// Ports: CCLK/RST_N plain; bus (slave modport) carries LCDE/LCDRS/LCDRW/LCDDAT in and
// strdata, cursor, disp_on, four_bit, byte_valid, byte_out, byte_rs, proto_err out.
module lcd_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  BLANK       = 8'h20
) (
  input logic               CCLK,
  input logic               RST_N,
  lcd_bus_monitor_if.slave  bus
);

  typedef enum logic {PH_HIGH = 1'b0, PH_LOW = 1'b1} phase_t;

  // Reset asserts immediately, releases two CCLK edges after RST_N rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Bus synchronizers. LCDE carries one extra history flop so the fall is
  // seen when the last synchronizer stage goes low; RS/RW/DAT are read from
  // that same last stage.
  logic [SYNC_STAGES:0]        r_e_sync;
  logic [SYNC_STAGES-1:0]      r_rs_sync;
  logic [SYNC_STAGES-1:0]      r_rw_sync;
  logic [SYNC_STAGES-1:0][3:0] r_dat_sync;

  always_ff @(posedge CCLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_e_sync   <= '0;
      r_rs_sync  <= '0;
      r_rw_sync  <= '0;
      r_dat_sync <= '0;
    end else begin
      r_e_sync   <= {r_e_sync[SYNC_STAGES-1:0], bus.LCDE};
      r_rs_sync  <= {r_rs_sync[SYNC_STAGES-2:0], bus.LCDRS};
      r_rw_sync  <= {r_rw_sync[SYNC_STAGES-2:0], bus.LCDRW};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], bus.LCDDAT};
    end
  end

  logic       w_wr_stb;
  logic       w_stb_rs;
  logic [3:0] w_stb_dat;

  assign w_stb_rs  = r_rs_sync[SYNC_STAGES-1];
  assign w_stb_dat = r_dat_sync[SYNC_STAGES-1];
  // Read strobes are dropped here so they never touch the nibble phase.
  assign w_wr_stb  = r_e_sync[SYNC_STAGES] & ~r_e_sync[SYNC_STAGES-1] & ~r_rw_sync[SYNC_STAGES-1];

  // Decoder state
  phase_t           r_phase;
  phase_t           w_phase_nxt;
  logic [3:0]       r_hi;
  logic             r_hi_rs;
  logic             r_four_bit;
  logic             r_inc;
  logic             r_disp_on;
  logic             r_proto_err;
  logic [4:0]       r_cursor;
  logic [0:31][7:0] r_cells;       // cell 0 occupies the top byte of strdata
  logic             r_byte_valid;
  logic [7:0]       r_byte_out;
  logic             r_byte_rs;

  logic       w_byte_vld;
  logic [7:0] w_byte;
  logic       w_byte_rs;
  logic       w_rs_mis;

  // Nibble assembly: phase transitions and the byte completed this cycle.
  always_comb begin
    w_phase_nxt = r_phase;
    w_byte_vld  = 1'b0;
    w_byte      = 8'h00;
    w_byte_rs   = 1'b0;
    w_rs_mis    = 1'b0;
    if (w_wr_stb) begin
      if (!r_four_bit) begin
        w_byte_vld = 1'b1;
        w_byte     = {w_stb_dat, 4'h0};
        w_byte_rs  = w_stb_rs;
      end else if (r_phase == PH_HIGH) begin
        w_phase_nxt = PH_LOW;
      end else begin
        w_byte_vld  = 1'b1;
        w_byte      = {r_hi, w_stb_dat};
        w_byte_rs   = r_hi_rs;
        w_rs_mis    = (r_hi_rs != w_stb_rs);
        w_phase_nxt = PH_HIGH;
      end
      // Any function set re-aligns to the high nibble.
      if (w_byte_vld && !w_byte_rs && (w_byte[7:5] == 3'b001)) w_phase_nxt = PH_HIGH;
    end
  end

  always_ff @(posedge CCLK or negedge w_rst_n) begin
    if (!w_rst_n) r_phase <= PH_HIGH;
    else          r_phase <= w_phase_nxt;
  end

  always_ff @(posedge CCLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hi         <= 4'h0;
      r_hi_rs      <= 1'b0;
      r_four_bit   <= 1'b0;
      r_inc        <= 1'b1;
      r_disp_on    <= 1'b0;
      r_proto_err  <= 1'b0;
      r_cursor     <= 5'd0;
      r_cells      <= {32{BLANK}};
      r_byte_valid <= 1'b0;
      r_byte_out   <= 8'h00;
      r_byte_rs    <= 1'b0;
    end else begin
      r_byte_valid <= w_byte_vld;
      if (w_wr_stb && r_four_bit && (r_phase == PH_HIGH)) begin
        r_hi    <= w_stb_dat;
        r_hi_rs <= w_stb_rs;
      end
      if (w_byte_vld) begin
        r_byte_out <= w_byte;
        r_byte_rs  <= w_byte_rs;
        if (w_rs_mis) r_proto_err <= 1'b1;
        if (w_byte_rs) begin
          r_cells[r_cursor] <= w_byte;
          r_cursor          <= r_inc ? r_cursor + 5'd1 : r_cursor - 5'd1;
        end else if (w_byte[7]) begin
          // DDRAM address: only 0x00-0x0F and 0x40-0x4F map onto the 2x16 buffer.
          if (w_byte[5:4] != 2'b00) r_proto_err <= 1'b1;
          else                      r_cursor    <= {w_byte[6], w_byte[3:0]};
        end else if (w_byte[6]) begin
          // CGRAM address: no visible effect on the text buffer.
        end else if (w_byte[5]) begin
          r_four_bit <= ~w_byte[4];
        end else if (w_byte[4]) begin
          // Only cursor moves are tracked; display shifts leave the buffer alone.
          if (!w_byte[3]) r_cursor <= w_byte[2] ? r_cursor + 5'd1 : r_cursor - 5'd1;
        end else if (w_byte[3]) begin
          r_disp_on <= w_byte[2];
        end else if (w_byte[2]) begin
          r_inc <= w_byte[1];
        end else if (w_byte[1]) begin
          r_cursor <= 5'd0;
        end else if (w_byte[0]) begin
          r_cells  <= {32{BLANK}};
          r_cursor <= 5'd0;
          r_inc    <= 1'b1;
        end
      end
    end
  end

  assign bus.strdata    = r_cells;
  assign bus.cursor     = r_cursor;
  assign bus.disp_on    = r_disp_on;
  assign bus.four_bit   = r_four_bit;
  assign bus.byte_valid = r_byte_valid;
  assign bus.byte_out   = r_byte_out;
  assign bus.byte_rs    = r_byte_rs;
  assign bus.proto_err  = r_proto_err;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Self-checking bench for lcd_bus_monitor: directed LCD bus traffic, a
// behavioural display model compared every cycle, plus literal spot checks.
module tb_lcd_bus_monitor;
  logic clk;
  logic rst_n;
  lcd_bus_monitor_if bus();

  lcd_bus_monitor #(.SYNC_STAGES(2), .BLANK(8'h20)) dut (
    .CCLK  (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_bv   = 0;
  int last_drop = 0;
  int last_bv   = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int           due;
    logic [7:0]   b;
    logic         rs;
    logic [255:0] s;
    logic [4:0]   cur;
    logic         don;
    logic         fb;
    logic         err;
  } ev_t;

  ev_t q[$];
  logic [7:0] m_cells [32];
  int   m_cur;
  bit   m_inc, m_don, m_fb, m_err, m_phase_lo, m_hirs;
  logic [3:0] m_hi;

  // Values the DUT outputs should currently show.
  logic [255:0] e_s;
  logic [4:0]   e_cur;
  logic         e_don, e_fb, e_err, e_brs;
  logic [7:0]   e_bo;

  function automatic logic [255:0] pack_cells();
    logic [255:0] s;
    for (int i = 0; i < 32; i++) s[255-8*i -: 8] = m_cells[i];
    return s;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
    m_cur = 0; m_inc = 1; m_don = 0; m_fb = 0; m_err = 0;
    m_phase_lo = 0; m_hi = 4'h0; m_hirs = 0;
    q.delete();
    e_s = pack_cells(); e_cur = 5'd0; e_don = 0; e_fb = 0; e_err = 0;
    e_bo = 8'h00; e_brs = 0;
  endtask

  task automatic m_apply(input logic [7:0] b, input logic rs);
    int a;
    if (rs) begin
      m_cells[m_cur] = b;
      m_cur = (m_cur + (m_inc ? 1 : 31)) % 32;
    end else if (b >= 8'h80) begin
      a = int'(b) - 128;
      if ((a / 16) % 4 != 0) m_err = 1;
      else m_cur = (a >= 64 ? 16 : 0) + (a % 16);
    end else if (b >= 8'h40) begin
      a = 0;
    end else if (b >= 8'h20) begin
      m_fb = ((b / 16) % 2 == 0);
      m_phase_lo = 0;
    end else if (b >= 8'h10) begin
      if ((b / 8) % 2 == 0) m_cur = (m_cur + (((b / 4) % 2 == 1) ? 1 : 31)) % 32;
    end else if (b >= 8'h08) begin
      m_don = ((b / 4) % 2 == 1);
    end else if (b >= 8'h04) begin
      m_inc = ((b / 2) % 2 == 1);
    end else if (b >= 8'h02) begin
      m_cur = 0;
    end else if (b == 8'h01) begin
      for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
      m_cur = 0;
      m_inc = 1;
    end
  endtask

  // Called at the moment LCDE is dropped; the result becomes visible on the
  // third rising edge afterwards (two synchronizer stages plus the decode edge).
  task automatic m_strobe(input logic rs, input logic rw, input logic [3:0] d);
    ev_t e;
    logic [7:0] b;
    logic brs;
    if (rw) return;
    if (!m_fb) begin
      b = {d, 4'h0}; brs = rs;
    end else if (!m_phase_lo) begin
      m_hi = d; m_hirs = rs; m_phase_lo = 1;
      return;
    end else begin
      b = {m_hi, d}; brs = m_hirs;
      if (m_hirs != rs) m_err = 1;
      m_phase_lo = 0;
    end
    m_apply(b, brs);
    e.due = cyc + 3; e.b = b; e.rs = brs; e.s = pack_cells();
    e.cur = 5'(m_cur); e.don = m_don; e.fb = m_fb; e.err = m_err;
    q.push_back(e);
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (mon_en) begin
        if (q.size() > 0 && q[0].due == cyc) begin
          e_s = q[0].s; e_cur = q[0].cur; e_don = q[0].don; e_fb = q[0].fb;
          e_err = q[0].err; e_bo = q[0].b; e_brs = q[0].rs;
          void'(q.pop_front());
          chk("byte_valid", {255'd0, bus.byte_valid}, 256'd1);
        end else begin
          chk("byte_valid", {255'd0, bus.byte_valid}, 256'd0);
        end
        if (bus.byte_valid) begin n_bv++; last_bv = cyc; end
        chk("strdata",   bus.strdata, e_s);
        chk("cursor",    {251'd0, bus.cursor}, {251'd0, e_cur});
        chk("disp_on",   {255'd0, bus.disp_on}, {255'd0, e_don});
        chk("four_bit",  {255'd0, bus.four_bit}, {255'd0, e_fb});
        chk("proto_err", {255'd0, bus.proto_err}, {255'd0, e_err});
        chk("byte_out",  {248'd0, bus.byte_out}, {248'd0, e_bo});
        chk("byte_rs",   {255'd0, bus.byte_rs}, {255'd0, e_brs});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic strobe(input logic rs, input logic rw, input logic [3:0] d);
    @(negedge clk);
    bus.LCDRS = rs; bus.LCDRW = rw; bus.LCDDAT = d;
    repeat (2) @(negedge clk);
    bus.LCDE = 1'b1;
    repeat (2) @(negedge clk);
    bus.LCDE = 1'b0;
    last_drop = cyc;
    m_strobe(rs, rw, d);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    strobe(rs, 1'b0, b[7:4]);
    strobe(rs, 1'b0, b[3:0]);
  endtask

  localparam logic [255:0] ALL_BLANK = {32{8'h20}};
  logic [255:0] s;
  int mark;
  string txt;

  initial begin
    bus.LCDE = 0; bus.LCDRS = 0; bus.LCDRW = 0; bus.LCDDAT = 4'h0;
    rst_n = 0;
    m_reset();
    repeat (3) @(posedge clk);
    mon_en = 1;
    @(negedge clk); rst_n = 1;
    repeat (5) @(negedge clk);

    // Reset state, pinned by literals.
    chk("rst_strdata",  bus.strdata, ALL_BLANK);
    chk("rst_cursor",   {251'd0, bus.cursor}, 256'd0);
    chk("rst_four_bit", {255'd0, bus.four_bit}, 256'd0);
    chk("rst_disp_on",  {255'd0, bus.disp_on}, 256'd0);
    chk("rst_proto",    {255'd0, bus.proto_err}, 256'd0);

    // Initialisation: three 8-bit 0x3 strobes, switch with 0x2, then 4-bit setup.
    mark = n_bv;
    strobe(0, 0, 4'h3);
    chk("init_30", {248'd0, bus.byte_out}, 256'h30);
    strobe(0, 0, 4'h3);
    strobe(0, 0, 4'h3);
    strobe(0, 0, 4'h2);
    chk("init_20", {248'd0, bus.byte_out}, 256'h20);
    chk("init_fb", {255'd0, bus.four_bit}, 256'd1);
    send_byte(0, 8'h28);
    send_byte(0, 8'h0C);
    send_byte(0, 8'h06);
    send_byte(0, 8'h01);
    // Four 8-bit strobes plus four complete 4-bit bytes.
    chk("init_pulses", 256'(n_bv - mark), 256'd8);
    chk("init_blank",  bus.strdata, ALL_BLANK);
    chk("init_don",    {255'd0, bus.disp_on}, 256'd1);

    // Line 1 text.
    send_byte(0, 8'h80);
    txt = "ADDR";
    for (int i = 0; i < 4; i++) begin
      send_byte(1, txt[i]);
      chk("latency", 256'(last_bv - last_drop), 256'd3);
    end
    s = bus.strdata;
    chk("addr_text", {224'd0, s[255:224]}, 256'h41444452);
    chk("addr_cursor", {251'd0, bus.cursor}, 256'd4);

    // Line 2 overflow wraps into cell 0.
    send_byte(0, 8'hC0);
    chk("line2_cursor", {251'd0, bus.cursor}, 256'd16);
    for (int i = 0; i < 17; i++) send_byte(1, 8'h61 + 8'(i));
    s = bus.strdata;
    chk("wrap_cell0",  {248'd0, s[255:248]}, 256'h71);
    chk("wrap_cell16", {248'd0, s[127:120]}, 256'h61);
    chk("wrap_cell31", {248'd0, s[7:0]}, 256'h70);
    chk("wrap_cursor", {251'd0, bus.cursor}, 256'd1);

    // RS mismatch between nibbles: flagged, still written as data.
    strobe(1, 0, 4'h4);
    strobe(0, 0, 4'h2);
    s = bus.strdata;
    chk("mis_err",  {255'd0, bus.proto_err}, 256'd1);
    chk("mis_byte", {248'd0, bus.byte_out}, 256'h42);
    chk("mis_rs",   {255'd0, bus.byte_rs}, 256'd1);
    chk("mis_cell", {248'd0, s[247:240]}, 256'h42);
    chk("mis_cur",  {251'd0, bus.cursor}, 256'd2);

    // Out-of-range DDRAM address: error stays, cursor untouched.
    send_byte(0, 8'hB0);
    chk("b0_err", {255'd0, bus.proto_err}, 256'd1);
    chk("b0_cur", {251'd0, bus.cursor}, 256'd2);

    // Read strobe between nibbles is invisible.
    strobe(1, 0, 4'h5);
    strobe(1, 1, 4'hF);
    strobe(1, 0, 4'h8);
    s = bus.strdata;
    chk("rw_byte", {248'd0, bus.byte_out}, 256'h58);
    chk("rw_cell", {248'd0, s[239:232]}, 256'h58);

    // Cursor shift left then display shift (ignored).
    send_byte(0, 8'h10);
    chk("shift_l", {251'd0, bus.cursor}, 256'd2);
    send_byte(0, 8'h1C);
    chk("shift_sc", {251'd0, bus.cursor}, 256'd2);

    // Reset mid-byte discards the pending nibble.
    strobe(1, 0, 4'h4);
    @(negedge clk); rst_n = 0; m_reset();
    repeat (2) @(negedge clk); rst_n = 1;
    repeat (4) @(negedge clk);
    chk("mrst_strdata", bus.strdata, ALL_BLANK);
    chk("mrst_fb",      {255'd0, bus.four_bit}, 256'd0);
    chk("mrst_err",     {255'd0, bus.proto_err}, 256'd0);
    chk("mrst_cursor",  {251'd0, bus.cursor}, 256'd0);
    strobe(0, 0, 4'h3);
    chk("mrst_8bit", {248'd0, bus.byte_out}, 256'h30);
    chk("mrst_fb2",  {255'd0, bus.four_bit}, 256'd0);

    repeat (4) @(negedge clk);
    chk("queue_drained", 256'(q.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
